// File: rtl/rob_issue_port_pkg.sv
// Shared constants and types for the decoder-to-ROB issue port.
//   REG_ID_BIT / ROB_WIDTH_BIT : register-index and ROB-tag widths
//   OP_*_CODE                  : op_type codes that serialise the issue stream
//   issue_state_e              : issue FSM encoding
//   issue_entry_t              : one buffered decoded instruction
package rob_issue_port_pkg;

  localparam int unsigned REG_ID_BIT    = 5;
  localparam int unsigned ROB_WIDTH_BIT = 3;
  localparam int unsigned ROB_WIDTH     = 1 << ROB_WIDTH_BIT;

  localparam logic [5:0] OP_JALR_CODE = 6'd3;
  localparam logic [5:0] OP_EXIT_CODE = 6'd39;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StWaitJalr = 2'd1,
    StHalt     = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [5:0]            op_type;
    logic [REG_ID_BIT-1:0] rd;
    logic [REG_ID_BIT-1:0] rs1;
    logic [REG_ID_BIT-1:0] rs2;
    logic [31:0]           imm;
    logic [31:0]           pc;
    logic [31:0]           inst_pc;
  } issue_entry_t;

  localparam int unsigned ISSUE_ENTRY_W = $bits(issue_entry_t);

endpackage

// File: rtl/rob_issue_port_issue_fifo.sv
// Generic Depth-entry synchronous FIFO with occupancy count and flush.
//   clk_in, rst_in : clock, async active-low reset
//   push, wdata    : write request (ignored when full or flushing)
//   pop, rdata     : read request (ignored when empty or flushing); rdata is the head
//   flush          : drop all entries this cycle
//   count, full, empty : occupancy status
module rob_issue_port_issue_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  input  logic             flush,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  // No write-through: a full FIFO refuses a push even if it pops this cycle.
  assign push_ok = push & ~flush & ~full;
  assign pop_ok  = pop & ~flush & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rob_issue_port.sv
// Producer side of the decoder-to-ROB issue interface.
// Buffers decoded instructions and issues at most one per cycle to the ROB,
// stalling after a jalr until it resolves and stopping for good after exit.
//   clk_in, rst_in, rdy_in          : clock, async active-low reset, global pause
//   dec_*                           : decoder handshake and instruction fields
//   to_rob, pc..rs2                 : issue strobe and head-entry fields
//   rob_full, rob_free_id           : ROB back-pressure and tag offered this cycle
//   issued_tag                      : tag of the last issued instruction
//   jalr_resolved, flush            : control pulses (ignored while paused)
//   halted, fifo_count              : status
module rob_issue_port
  import rob_issue_port_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [5:0]  OP_JALR = OP_JALR_CODE,
  parameter logic [5:0]  OP_EXIT = OP_EXIT_CODE,
  localparam int unsigned CntW   = $clog2(DEPTH) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [31:0]              dec_pc,
  input  logic [31:0]              dec_inst_pc,
  input  logic [31:0]              dec_imm,
  input  logic [5:0]               dec_op_type,
  input  logic [REG_ID_BIT-1:0]    dec_rd,
  input  logic [REG_ID_BIT-1:0]    dec_rs1,
  input  logic [REG_ID_BIT-1:0]    dec_rs2,
  output logic                     to_rob,
  output logic [31:0]              pc,
  output logic [31:0]              inst_pc,
  output logic [31:0]              imm,
  output logic [5:0]               op_type,
  output logic [REG_ID_BIT-1:0]    rd,
  output logic [REG_ID_BIT-1:0]    rs1,
  output logic [REG_ID_BIT-1:0]    rs2,
  input  logic                     rob_full,
  input  logic [ROB_WIDTH_BIT-1:0] rob_free_id,
  output logic [ROB_WIDTH_BIT-1:0] issued_tag,
  input  logic                     jalr_resolved,
  input  logic                     flush,
  output logic                     halted,
  output logic [CntW-1:0]          fifo_count
);

  issue_state_e               state_q;
  logic [ROB_WIDTH_BIT-1:0]   issued_tag_q;
  issue_entry_t               wr_entry, head;
  logic                       fifo_full, fifo_empty;
  logic                       flush_eff, push;

  assign wr_entry = '{
    op_type: dec_op_type,
    rd:      dec_rd,
    rs1:     dec_rs1,
    rs2:     dec_rs2,
    imm:     dec_imm,
    pc:      dec_pc,
    inst_pc: dec_inst_pc
  };

  // Pulses are only honoured while running; a paused cycle is a no-op.
  assign flush_eff = rdy_in & flush;
  assign dec_ready = rdy_in & ~flush & ~fifo_full;
  assign push      = dec_valid & dec_ready;
  assign to_rob    = rdy_in & ~flush & (state_q == StRun) & ~fifo_empty & ~rob_full;

  rob_issue_port_issue_fifo #(
    .Depth (DEPTH),
    .Width (ISSUE_ENTRY_W)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push),
    .wdata  (wr_entry),
    .pop    (to_rob),
    .rdata  (head),
    .flush  (flush_eff),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StRun;
      issued_tag_q <= '0;
    end else if (rdy_in) begin
      if (to_rob) issued_tag_q <= rob_free_id;
      if (flush) begin
        // Flush discards the speculative path behind a jalr but never un-halts.
        if (state_q == StWaitJalr) state_q <= StRun;
      end else begin
        case (state_q)
          StRun: begin
            if (to_rob && head.op_type == OP_JALR)      state_q <= StWaitJalr;
            else if (to_rob && head.op_type == OP_EXIT) state_q <= StHalt;
          end
          StWaitJalr: if (jalr_resolved) state_q <= StRun;
          StHalt:     state_q <= StHalt;
          default:    state_q <= StRun;
        endcase
      end
    end
  end

  assign issued_tag = issued_tag_q;
  assign halted     = (state_q == StHalt);
  assign pc         = head.pc;
  assign inst_pc    = head.inst_pc;
  assign imm        = head.imm;
  assign op_type    = head.op_type;
  assign rd         = head.rd;
  assign rs1        = head.rs1;
  assign rs2        = head.rs2;

endmodule

// File: tb/tb_rob_issue_port.sv
module tb_rob_issue_port;
  import rob_issue_port_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [5:0]  JALR  = 6'd3;
  localparam logic [5:0]  EXIT  = 6'd39;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst_pc, dec_imm;
  logic [5:0]  dec_op_type;
  logic [REG_ID_BIT-1:0] dec_rd, dec_rs1, dec_rs2;
  logic to_rob;
  logic [31:0] pc, inst_pc, imm;
  logic [5:0]  op_type;
  logic [REG_ID_BIT-1:0] rd, rs1, rs2;
  logic rob_full;
  logic [ROB_WIDTH_BIT-1:0] rob_free_id, issued_tag;
  logic jalr_resolved, flush, halted;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk_in = ~clk_in;

  rob_issue_port #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_inst_pc(dec_inst_pc), .dec_imm(dec_imm),
    .dec_op_type(dec_op_type), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .to_rob(to_rob), .pc(pc), .inst_pc(inst_pc), .imm(imm), .op_type(op_type),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .rob_full(rob_full), .rob_free_id(rob_free_id), .issued_tag(issued_tag),
    .jalr_resolved(jalr_resolved), .flush(flush), .halted(halted),
    .fifo_count(fifo_count)
  );

  // Reference model: an in-order queue plus two sticky flags.
  issue_entry_t mq[$];
  bit m_wait, m_halt;
  logic [ROB_WIDTH_BIT-1:0] m_tag;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return rdy_in && !flush && (mq.size() != DEPTH);
  endfunction

  function automatic bit exp_issue();
    return rdy_in && !flush && !m_wait && !m_halt && (mq.size() != 0) && !rob_full;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wait = 1'b0;
    m_halt = 1'b0;
    m_tag  = '0;
  endtask

  task automatic drive(input bit v, input logic [5:0] op);
    dec_valid   = v;
    dec_op_type = op;
    dec_pc      = $urandom;
    dec_inst_pc = $urandom;
    dec_imm     = $urandom;
    dec_rd      = REG_ID_BIT'($urandom);
    dec_rs1     = REG_ID_BIT'($urandom);
    dec_rs2     = REG_ID_BIT'($urandom);
  endtask

  // Check every output mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    bit iss, acc;
    issue_entry_t ne, e;
    @(negedge clk_in);
    check("dec_ready", 128'(dec_ready), 128'(exp_ready()));
    check("to_rob", 128'(to_rob), 128'(exp_issue()));
    check("fifo_count", 128'(fifo_count), 128'(mq.size()));
    check("halted", 128'(halted), 128'(m_halt));
    check("issued_tag", 128'(issued_tag), 128'(m_tag));
    if (mq.size() != 0)
      check("head_fields", 128'({op_type, rd, rs1, rs2, imm, pc, inst_pc}), 128'(mq[0]));
    iss = exp_issue();
    acc = exp_ready() && dec_valid;
    ne  = '{op_type: dec_op_type, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
            imm: dec_imm, pc: dec_pc, inst_pc: dec_inst_pc};
    @(posedge clk_in);
    if (!rst_in) begin
      model_reset();
    end else if (rdy_in) begin
      if (flush) begin
        mq.delete();
        m_wait = 1'b0;
      end else begin
        if (iss) begin
          e = mq.pop_front();
          m_tag = rob_free_id;
          if (e.op_type == JALR) m_wait = 1'b1;
          else if (e.op_type == EXIT) m_halt = 1'b1;
        end else if (m_wait && jalr_resolved) begin
          m_wait = 1'b0;
        end
        if (acc) mq.push_back(ne);
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges must clear state before the next edge.
  task automatic async_reset();
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_count", 128'(fifo_count), 128'(0));
    check("async_rst_to_rob", 128'(to_rob), 128'(0));
    check("async_rst_halted", 128'(halted), 128'(0));
    model_reset();
    cycle();
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_full = 1'b0; rob_free_id = '0;
    jalr_resolved = 1'b0; flush = 1'b0;
    drive(1'b0, 6'd0);
    model_reset();
    #2;
    check("reset_count", 128'(fifo_count), 128'(0));
    check("reset_to_rob", 128'(to_rob), 128'(0));
    check("reset_tag", 128'(issued_tag), 128'(0));
    cycle();
    cycle();
    rst_in = 1'b1;

    // Back-to-back issue of three entries, tags 0,1,2.
    drive(1'b1, 6'd10); rob_free_id = 3'd0; cycle();
    drive(1'b1, 6'd11); rob_free_id = 3'd0; cycle();
    drive(1'b1, 6'd12); rob_free_id = 3'd1; cycle();
    drive(1'b0, 6'd0);  rob_free_id = 3'd2; cycle();
    cycle();
    check("tag_after_three", 128'(issued_tag), 128'(2));

    // ROB full: FIFO fills to DEPTH and refuses the fifth push.
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'(20 + i));
      cycle();
    end
    drive(1'b0, 6'd0);
    check("full_count", 128'(fifo_count), 128'(DEPTH));
    check("full_ready", 128'(dec_ready), 128'(0));
    rob_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rob_free_id = 3'(4 + i);
      cycle();
    end

    // jalr stalls the following add until resolved.
    drive(1'b1, JALR);  cycle();
    drive(1'b1, 6'd10); cycle();
    drive(1'b0, 6'd0);
    repeat (5) cycle();
    check("jalr_stall_count", 128'(fifo_count), 128'(1));
    jalr_resolved = 1'b1; cycle();
    jalr_resolved = 1'b0; cycle();
    check("after_resolve_count", 128'(fifo_count), 128'(0));

    // exit halts permanently; resolve and flush do not release it.
    drive(1'b1, EXIT);  cycle();
    drive(1'b1, 6'd10); cycle();
    drive(1'b0, 6'd0);
    repeat (3) cycle();
    jalr_resolved = 1'b1; cycle();
    jalr_resolved = 1'b0;
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();
    check("halt_sticky", 128'(halted), 128'(1));
    async_reset();

    // Flush drops buffered entries and the flush-cycle input.
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(40 + i));
      cycle();
    end
    drive(1'b1, 6'd50); flush = 1'b1; cycle();
    flush = 1'b0;
    check("flush_count", 128'(fifo_count), 128'(0));
    drive(1'b1, 6'd60); rob_full = 1'b0; cycle();
    drive(1'b0, 6'd0); cycle();

    // Pause: nothing moves while rdy_in is low.
    rob_full = 1'b1;
    drive(1'b1, 6'd7); cycle();
    drive(1'b1, 6'd8); cycle();
    rob_full = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(30 + i));
      cycle();
    end
    check("pause_count", 128'(fifo_count), 128'(2));
    rdy_in = 1'b1;
    drive(1'b1, 6'd9); cycle();
    async_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      rdy_in        = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      jalr_resolved = ($urandom_range(0, 4) == 0);
      rob_full      = ($urandom_range(0, 2) == 0);
      rob_free_id   = ROB_WIDTH_BIT'($urandom);
      r = $urandom_range(0, 19);
      if (r == 0)     drive($urandom_range(0, 1) == 1, EXIT);
      else if (r < 5) drive($urandom_range(0, 1) == 1, JALR);
      else            drive($urandom_range(0, 1) == 1, 6'($urandom_range(4, 38)));
      cycle();
      if (n % 60 == 59) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_issue_port.md
Name: rob_issue_port

Overview:
- Producer side of the Decoder→ROB issue interface.
- Buffers decoded instructions from the decoder in a small FIFO and drives to_rob plus the entry fields, at most one per cycle, only while the ROB is not full.
- Enforces serialisation rules on the issue stream: stalls after issuing a jalr until it resolves, and stops permanently after issuing exit.
- Reports the ROB tag assigned to each issued instruction back to rename/RS logic.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- REG_ID_BIT, 5, register index width (shared constant).
- ROB_WIDTH_BIT, 3, ROB tag width (shared constant).
- OP_JALR, 6'd3, op_type code for jalr.
- OP_EXIT, 6'd39, op_type code for exit.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global pause when low.
- dec_valid  in  1  decoder offers an instruction.
- dec_ready  out  1  FIFO accepts this cycle.
- dec_pc, dec_inst_pc, dec_imm  in  32 each  instruction fields.
- dec_op_type  in  6  operation code.
- dec_rd, dec_rs1, dec_rs2  in  REG_ID_BIT each  register ids.
- to_rob  out  1  issue strobe to ROB.
- pc, inst_pc, imm  out  32 each  FIFO head fields.
- op_type  out  6  FIFO head field.
- rd, rs1, rs2  out  REG_ID_BIT each  FIFO head fields.
- rob_full  in  1  ROB cannot accept.
- rob_free_id  in  ROB_WIDTH_BIT  tag the ROB assigns this cycle.
- issued_tag  out  ROB_WIDTH_BIT  tag of the last issued instruction, registered.
- jalr_resolved  in  1  pulse: outstanding jalr target known.
- flush  in  1  pulse: discard all buffered, un-issued instructions.
- halted  out  1  exit has been issued.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst_in=0, async): FIFO empty, rd_ptr=wr_ptr=0, count=0, state=RUN, issued_tag=0.
  - Resulting outputs: to_rob=0, halted=0, dec_ready=1 once rdy_in is high.
  - Reset mid-operation drops all entries and the state immediately.
- FIFO storage:
  - Registered storage, pointers wrap modulo DEPTH.
  - dec_ready = rdy_in & !flush & (count != DEPTH).
  - No write-through when full, even if a pop occurs the same cycle.
- Accept: dec_valid & dec_ready at edge t → entry written, count+1. The earliest issue of that entry is cycle t+1; there is no bypass.
- Issue:
  - to_rob = rdy_in & !flush & (state==RUN) & (count!=0) & !rob_full.
  - All field outputs come combinationally from the head entry (drive them even when to_rob=0).
  - On issue: rd_ptr+1, count−1, issued_tag<=rob_free_id.
- Simultaneous accept and issue: count unchanged, both pointers advance.
- State machine (RUN, WAIT_JALR, HALT):
  - RUN: issuing op_type==OP_JALR → WAIT_JALR. Issuing op_type==OP_EXIT → HALT. Otherwise stay in RUN.
  - WAIT_JALR: no issue. jalr_resolved → RUN, and issue may resume the next cycle.
  - HALT: no issue, halted=1. Only reset leaves this state. dec_ready still follows FIFO space.
  - jalr_resolved in RUN or HALT is ignored.
- Flush:
  - Clears the FIFO (count=0, rd_ptr=wr_ptr).
  - In the flush cycle: dec input is dropped and to_rob=0.
  - State effect: WAIT_JALR→RUN; HALT is kept.
  - flush together with jalr_resolved: flush wins, result is RUN.
- rdy_in=0: no accept, no issue, and all registers hold, including pending jalr_resolved/flush pulses. Those pulses are ignored while paused, so the sender must hold or reissue them.
- rob_full is sampled combinationally each cycle. The ROB updates fullness registered, so one issue per cycle cannot overflow it.

Decomposition:
- Shared const.v: REG_ID_BIT, ROB_WIDTH_BIT, ROB_WIDTH, op_type codes (OP_JALR=3, OP_EXIT=39), state encoding localparams.
- Packed struct ISSUE_ENTRY {op_type, rd, rs1, rs2, imm, pc, inst_pc} goes alongside.
- One natural sub-module: issue_fifo (generic DEPTH-entry synchronous FIFO with count, flush, async active-low reset). The FSM and issue gating stay in rob_issue_port.

Test Plan:
- Reset, then push op_types 10, 11, 12 on consecutive cycles with rob_full=0, rob_free_id 0,1,2 → to_rob high on cycles 1–3 with op_type 10, 11, 12; issued_tag=2 afterwards.
- Hold rob_full=1 and push 5 entries → dec_ready low after 4 accepts, fifo_count=4, to_rob=0. Release rob_full → 4 issues on 4 consecutive cycles, in order.
- Push jalr (3) then add (10) → jalr issues, add is held for 5 cycles. jalr_resolved pulse → add issues the next cycle.
- Push exit (39) then 10 → exit issues, halted=1, and 10 is never issued. jalr_resolved and flush leave halted=1 until rst_in=0.
- Fill 3 entries with rob_full=1, then pulse flush with dec_valid=1 → fifo_count=0 and the flush-cycle input is dropped. The next push issues first.
- Hold rdy_in=0 for 3 cycles with dec_valid=1 and rob_full=0 → dec_ready=0, to_rob=0, fifo_count constant. Assert rst_in=0 mid-stream asynchronously → count=0 and to_rob=0 before the next edge.
